// File: rtl/cmd_pkg.sv
// Shared definitions for the host command path: protocol meta codes,
// the NOOP word, byte-assembly state encodings and the meta-valid check.
package cmd_pkg;

   localparam logic [4:0] PROTOCOL_NOOP        = 5'd0;
   localparam logic [4:0] PROTOCOL_FILTER_BIAS = 5'd1;
   localparam logic [4:0] PROTOCOL_DATA        = 5'd7;
   localparam logic [4:0] PROTOCOL_RUN_ACCEL   = 5'd8;
   localparam logic [4:0] PROTOCOL_LAST_CMD    = 5'd9;
   localparam logic [4:0] PROTOCOL_RST         = 5'd31;

   localparam logic [23:0] NOOP_WORD = 24'h000000;

   typedef enum logic [1:0] {
      B0 = 2'd0,
      B1 = 2'd1,
      B2 = 2'd2
   } byte_state_t;

   // Legal metas are the contiguous command range plus the reset command.
   function automatic logic meta_is_valid(input logic [4:0] meta);
      return (meta <= PROTOCOL_LAST_CMD) || (meta == PROTOCOL_RST);
   endfunction

   // Only commands that touch the running accelerator must wait for it.
   function automatic logic meta_waits_for_accel(input logic [4:0] meta);
      return (meta == PROTOCOL_DATA) || (meta == PROTOCOL_RUN_ACCEL);
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command-word FIFO with registered pointers and an extra
// wrap bit on each pointer to tell full from empty. DEPTH must be a
// power of two, at least 2.
module cmd_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout    = mem[rd_ptr[AW-1:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointer advance; reset empties the queue immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage write; contents need no reset because the pointers gate reads.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/host_cmd_framer.sv
// Host command framer: assembles 3-byte groups from the host into 24-bit
// command words, drops malformed words and stalled partials, queues the
// rest and replays each onto master_bus for one cycle (NOOP otherwise).
// Data and run commands are held at the queue head while the accelerator
// is busy. Optional macro CMD_PARITY_EN enables odd parity on bit 23.
module host_cmd_framer
   import cmd_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int SYNC_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  host_byte,
   input  logic        host_valid,
   output logic        host_ready,
   input  logic        accel_busy,
   output logic [23:0] master_bus,
   output logic        frame_err,
   output logic [7:0]  err_count
);

   localparam logic [7:0] IDLE_LAST = 8'(SYNC_TIMEOUT - 1);

   byte_state_t state;
   logic [7:0]  byte_hi;
   logic [7:0]  byte_mid;
   logic [7:0]  idle_cnt;

   logic        accept;
   logic        word_done;
   logic        meta_ok;
   logic        parity_ok;
   logic        push;
   logic        pop;
   logic        drop;
   logic        timeout;
   logic        stall;
   logic        fifo_full;
   logic        fifo_empty;
   logic [23:0] word_raw;
   logic [23:0] word_push;
   logic [23:0] fifo_head;

   // Host may send freely while collecting the first two bytes; the third
   // byte is only taken when the queue has room for the finished word.
   always_comb begin
      host_ready = 1'b0;
      if (rst) host_ready = (state != B2) || !fifo_full;
   end

   assign accept    = host_valid && host_ready;
   assign word_raw  = {byte_hi, byte_mid, host_byte};
   assign word_done = accept && (state == B2);
   assign meta_ok   = meta_is_valid(word_raw[22:18]);

`ifdef CMD_PARITY_EN
   assign parity_ok = ^word_raw;
   assign word_push = {1'b0, word_raw[22:0]};
`else
   assign parity_ok = 1'b1;
   assign word_push = word_raw;
`endif

   assign push    = word_done && meta_ok && parity_ok;
   assign drop    = word_done && !(meta_ok && parity_ok);
   assign timeout = (state != B0) && !accept && (idle_cnt == IDLE_LAST);
   assign stall   = accel_busy && meta_waits_for_accel(fifo_head[22:18]);
   assign pop     = !fifo_empty && !stall;

   cmd_fifo #(
      .WIDTH (24),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (word_push),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Byte assembly and resync: each accepted byte advances the slot, an
   // idle partial word is abandoned after SYNC_TIMEOUT quiet cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= B0;
         byte_hi  <= 8'h00;
         byte_mid <= 8'h00;
         idle_cnt <= 8'h00;
      end else if (timeout) begin
         state    <= B0;
         idle_cnt <= 8'h00;
      end else if (accept) begin
         idle_cnt <= 8'h00;
         case (state)
            B0: begin
               byte_hi <= host_byte;
               state   <= B1;
            end
            B1: begin
               byte_mid <= host_byte;
               state    <= B2;
            end
            B2:      state <= B0;
            default: state <= B0;
         endcase
      end else if (state != B0) begin
         idle_cnt <= idle_cnt + 8'd1;
      end
   end

   // Registered outputs: bus shows the popped word for one cycle, error
   // pulse and saturating error count follow every discard.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         master_bus <= NOOP_WORD;
         frame_err  <= 1'b0;
         err_count  <= 8'h00;
      end else begin
         master_bus <= pop ? fifo_head : NOOP_WORD;
         frame_err  <= drop || timeout;
         if ((drop || timeout) && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_host_cmd_framer.sv
// Self-checking bench for host_cmd_framer. A queue-based model of the
// framer is stepped once per cycle and compared against the DUT, while
// directed sequences pin hand-computed values along the way.
module tb_host_cmd_framer;

   localparam int FIFO_DEPTH   = 4;
   localparam int SYNC_TIMEOUT = 255;

   logic        clk;
   logic        rst;
   logic [7:0]  host_byte;
   logic        host_valid;
   logic        host_ready;
   logic        accel_busy;
   logic [23:0] master_bus;
   logic        frame_err;
   logic [7:0]  err_count;

   int tests;
   int fails;

   // Model state: bytes of the word in progress, idle cycles, queued words,
   // error tally, and the outputs expected after the coming edge.
   int          m_nb;
   logic [7:0]  m_pb [3];
   int          m_idle;
   int          m_errs;
   logic [23:0] m_q [$];
   logic [23:0] exp_bus;
   logic        exp_err;

   host_cmd_framer #(
      .FIFO_DEPTH   (FIFO_DEPTH),
      .SYNC_TIMEOUT (SYNC_TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .host_byte  (host_byte),
      .host_valid (host_valid),
      .host_ready (host_ready),
      .accel_busy (accel_busy),
      .master_bus (master_bus),
      .frame_err  (frame_err),
      .err_count  (err_count)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: bump the counters and report any difference.
   task automatic check_output(input string name, input logic [23:0] act, input logic [23:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // A word is kept when its meta is a known command (and, with parity on,
   // its popcount is odd).
   function automatic logic word_ok(input logic [23:0] w);
      logic [4:0] meta;
      logic       ok;
      meta = w[22:18];
      ok   = (meta <= 5'd9) || (meta == 5'd31);
`ifdef CMD_PARITY_EN
      ok = ok && ($countones(w) % 2 == 1);
`endif
      return ok;
   endfunction

   // Wait out one clock and land just after the rising edge, where all
   // stimulus changes are made.
   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Offer one byte and hold it until the DUT takes it, within a bound.
   task automatic apply_stimulus(input logic [7:0] b);
      int   guard;
      logic rdy;
      host_byte  = b;
      host_valid = 1'b1;
      guard      = 0;
      do begin
         @(negedge clk);
         rdy = host_ready;
         sync();
         guard++;
      end while (!rdy && guard < 50);
      if (!rdy) begin
         tests++;
         fails++;
         $display("[TB] FAIL handshake: host_ready stayed %0b, expected 1", rdy);
      end
      host_valid = 1'b0;
   endtask

   // Send a whole word; with parity on, bit 23 is set so the word is odd.
   task automatic send_word(input logic [23:0] w_in);
      logic [23:0] w;
      w = w_in;
`ifdef CMD_PARITY_EN
      w[23] = ~(^w[22:0]);
`endif
      apply_stimulus(w[23:16]);
      apply_stimulus(w[15:8]);
      apply_stimulus(w[7:0]);
   endtask

   // Per-cycle compare and model step on the falling edge: check what the
   // last rising edge produced, then predict the next one from the inputs.
   initial begin : compare_proc
      logic        acc;
      logic        popped;
      logic        discard;
      logic        do_push;
      logic        m_ready;
      logic [23:0] w;
      logic [23:0] head;
      logic [23:0] pw;
      m_nb = 0; m_idle = 0; m_errs = 0; exp_bus = '0; exp_err = 1'b0;
      pw = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check_output("reset_bus", master_bus, 24'h0);
            check_output("reset_err", {23'h0, frame_err}, 24'h0);
            check_output("reset_cnt", {16'h0, err_count}, 24'h0);
            check_output("reset_ready", {23'h0, host_ready}, 24'h0);
            m_nb = 0; m_idle = 0; m_errs = 0; exp_bus = '0; exp_err = 1'b0;
            m_q.delete();
         end else begin
            check_output("bus", master_bus, exp_bus);
            check_output("frame_err", {23'h0, frame_err}, {23'h0, exp_err});
            check_output("err_count", {16'h0, err_count}, 24'(m_errs));
            m_ready = (m_nb < 2) || (m_q.size() < FIFO_DEPTH);
            check_output("host_ready", {23'h0, host_ready}, {23'h0, m_ready});
            acc    = host_valid && m_ready;
            popped = 1'b0;
            if (m_q.size() > 0) begin
               head   = m_q[0];
               popped = !(accel_busy && (head[22:18] == 5'd7 || head[22:18] == 5'd8));
            end
            exp_bus = popped ? m_q[0] : 24'h0;
            discard = 1'b0;
            do_push = 1'b0;
            if (acc) begin
               m_pb[m_nb] = host_byte;
               m_nb++;
               m_idle = 0;
               if (m_nb == 3) begin
                  w    = {m_pb[0], m_pb[1], m_pb[2]};
                  m_nb = 0;
                  if (word_ok(w)) begin
                     do_push = 1'b1;
                     pw      = w;
`ifdef CMD_PARITY_EN
                     pw[23]  = 1'b0;
`endif
                  end else begin
                     discard = 1'b1;
                  end
               end
            end else if (m_nb > 0) begin
               m_idle++;
               if (m_idle == SYNC_TIMEOUT) begin
                  m_nb    = 0;
                  m_idle  = 0;
                  discard = 1'b1;
               end
            end
            if (popped)  void'(m_q.pop_front());
            if (do_push) m_q.push_back(pw);
            exp_err = discard;
            if (discard && m_errs < 255) m_errs++;
         end
      end
   end

   // Hard stop in case the design wedges somewhere unexpected.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequences with hand-computed expectations.
   initial begin : stim_proc
      logic [23:0] burst [4];
      tests = 0; fails = 0;
      rst = 1'b0; host_valid = 1'b0; host_byte = 8'h00; accel_busy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      sync();

      // Single FILTER_BIAS word: visible two edges after the third byte.
      send_word(24'h040020);
      @(negedge clk); check_output("bias_e0", master_bus, 24'h000000);
      @(negedge clk); check_output("bias_e1", master_bus, 24'h040020);
      @(negedge clk); check_output("bias_e2", master_bus, 24'h000000);
      sync();

      // Three DATA words held while busy, then released in order.
      accel_busy = 1'b1;
      send_word(24'h1C0001);
      send_word(24'h1C0002);
      send_word(24'h1C0003);
      repeat (3) sync();
      @(negedge clk); check_output("busy_hold", master_bus, 24'h000000);
      sync();
      accel_busy = 1'b0;
      @(negedge clk); check_output("release_e0", master_bus, 24'h000000);
      @(negedge clk); check_output("release_w1", master_bus, 24'h1C0001);
      @(negedge clk); check_output("release_w2", master_bus, 24'h1C0002);
      @(negedge clk); check_output("release_w3", master_bus, 24'h1C0003);
      @(negedge clk); check_output("release_end", master_bus, 24'h000000);
      sync();

      // Illegal meta 01100: dropped with one error pulse.
      send_word(24'h300000);
      @(negedge clk);
      check_output("badmeta_err", {23'h0, frame_err}, 24'h1);
      check_output("badmeta_cnt", {16'h0, err_count}, 24'h1);
      @(negedge clk);
      check_output("badmeta_pulse", {23'h0, frame_err}, 24'h0);
      check_output("badmeta_bus", master_bus, 24'h000000);
      sync();

      // Partial word abandoned after the idle timeout, then a clean word.
      apply_stimulus(8'h1C);
      apply_stimulus(8'h00);
      host_valid = 1'b0;
      repeat (SYNC_TIMEOUT) @(posedge clk);
      #1;
      @(negedge clk);
      check_output("timeout_err", {23'h0, frame_err}, 24'h1);
      check_output("timeout_cnt", {16'h0, err_count}, 24'h2);
      sync();
      send_word(24'h000000);
      repeat (3) sync();
      @(negedge clk); check_output("resync_cnt", {16'h0, err_count}, 24'h2);
      sync();

      // Fill the queue with stalled DATA words; only the third byte waits.
      accel_busy = 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         burst[i] = 24'h1C0010 + 24'(i);
         send_word(burst[i]);
      end
      @(negedge clk); check_output("full_b0_ready", {23'h0, host_ready}, 24'h1);
      sync();
      apply_stimulus(8'h1C);
      apply_stimulus(8'h00);
      host_byte  = 8'h14;
      host_valid = 1'b1;
      @(negedge clk); check_output("full_b2_ready", {23'h0, host_ready}, 24'h0);
      sync();
      @(negedge clk); check_output("full_b2_hold", {23'h0, host_ready}, 24'h0);
      sync();
      accel_busy = 1'b0;
      @(negedge clk); check_output("full_prepop", {23'h0, host_ready}, 24'h0);
      @(negedge clk);
      check_output("full_postpop", {23'h0, host_ready}, 24'h1);
      check_output("full_first", master_bus, 24'h1C0010);
      sync();
      host_valid = 1'b0;
      repeat (10) sync();

      // Reset mid-word clears the bus at once and loses the partial word.
      send_word(24'h040033);
      apply_stimulus(8'h1C);
      check_output("prereset_bus", master_bus, 24'h040033);
      rst = 1'b0;
      #1;
      check_output("async_bus", master_bus, 24'h000000);
      check_output("async_ready", {23'h0, host_ready}, 24'h0);
      sync();
      rst = 1'b1;
      sync();
      send_word(24'h000005);
      @(negedge clk); check_output("postreset_e0", master_bus, 24'h000000);
      @(negedge clk); check_output("postreset_e1", master_bus, 24'h000005);
      sync();

`ifdef CMD_PARITY_EN
      // Odd-parity word passes with bit 23 cleared; even-parity word drops.
      apply_stimulus(8'h88);
      apply_stimulus(8'h00);
      apply_stimulus(8'h01);
      @(negedge clk);
      @(negedge clk); check_output("parity_pass", master_bus, 24'h080001);
      sync();
      apply_stimulus(8'h08);
      apply_stimulus(8'h00);
      apply_stimulus(8'h01);
      @(negedge clk);
      check_output("parity_drop_err", {23'h0, frame_err}, 24'h1);
      check_output("parity_drop_cnt", {16'h0, err_count}, 24'h1);
      sync();
`endif

      // Error counter saturates at 255.
      for (int i = 0; i < 260; i++) send_word(24'h300000);
      @(negedge clk);
      check_output("sat_cnt", {16'h0, err_count}, 24'hFF);
      check_output("sat_err", {23'h0, frame_err}, 24'h1);
      repeat (3) sync();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/host_cmd_framer.md
# host_cmd_framer

Upstream feeder of the command interface. Accepts a byte stream from the host I/O port over a valid/ready handshake and assembles each 3-byte group into one 24-bit command word. Queues words in a small FIFO and replays each onto `master_bus` for exactly one cycle, driving NOOP otherwise. Holds back data and run commands while the accelerator is busy, and drops malformed words.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: command word FIFO depth; power of 2, minimum 2.
- `SYNC_TIMEOUT`, 255: idle cycles allowed inside a partial word before resync; 8-bit counter.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, asynchronous, active-low.
- `host_byte` in 8: host data byte.
- `host_valid` in 1: `host_byte` is valid.
- `host_ready` out 1: byte is accepted on an edge where `host_valid && host_ready`.
- `accel_busy` in 1: accelerator is running.
- `master_bus` out 24: command word. Bits 22:18 are meta, 17:0 are data, bit 23 is reserved.
- `frame_err` out 1: one-cycle pulse when a word or partial word is discarded.
- `err_count` out 8: saturating count of discarded words and partials.

## Operation
- Byte assembly FSM with states B0, B1, B2.
  - B0 accepts the first byte into bits 23:16, then goes to B1.
  - B1 accepts the second byte into bits 15:8, then goes to B2.
  - B2 accepts the third byte into bits 7:0, then returns to B0.
- `host_ready` is combinational:
  - 0 while `rst` = 0.
  - 1 in B0 and B1.
  - In B2, equals !fifo_full.
- On B2 acceptance, the completed word is validated:
  - Meta must be in 00000..01001 or 11111.
  - Any other meta drops the word: `frame_err` pulses and `err_count` increments.
  - A valid word is pushed into the FIFO.
- Timeout:
  - In B1 or B2, an idle counter increments every cycle with no accepted byte and clears on each accepted byte.
  - At `SYNC_TIMEOUT`, the FSM returns to B0, the partial word is discarded, `frame_err` pulses and `err_count` increments.
  - The counter is held at 0 in B0.
- Drain:
  - Each cycle, if the FIFO is non-empty and the head word is not stalled, pop the head into the `master_bus` register.
  - Otherwise load 24'h000000 (NOOP).
- Stall rule:
  - A head with meta DATA (00111) or RUN_ACCEL (01000) stalls while `accel_busy` = 1.
  - All other metas, including RST (11111), never stall.
  - Stalling is strictly in order; no word bypasses the head.
- No FIFO bypass: a word pushed into an empty FIFO pops on the following edge.
- Push and pop in the same edge are legal in any FIFO state, including a non-full FIFO with one free slot.
- `err_count` saturates at 255.

## Timing
- Reset values:
  - `master_bus` = 0.
  - `frame_err` = 0.
  - `err_count` = 0.
  - FSM in B0, FIFO empty, idle counter 0.
- Latency: third-byte handshake at edge E0 pushes the word; edge E1 pops it. The word is visible on `master_bus` from E1 to E2, then NOOP (or the next word) from E2.
- Each command occupies `master_bus` for exactly one cycle.
- Back-to-back FIFO entries appear on consecutive cycles.
- `frame_err` is registered: it asserts for the cycle after the discarding edge.
- Reset mid-word discards the partial word and FIFO contents immediately. `master_bus` goes to 0 asynchronously.

## Configuration
- `CMD_PARITY_EN` defined:
  - Bit 23 of the assembled word makes the total 24-bit popcount odd.
  - On mismatch, the word is dropped, `frame_err` pulses and `err_count` increments. This check is made in the same cycle as the meta check; a word failing both counts once.
  - Forwarded words have bit 23 cleared.
- `CMD_PARITY_EN` undefined: bit 23 passes through unchanged and is not checked.

## Structure
- Shared header package `cmd_pkg` holds:
  - PROTOCOL_* meta constants.
  - The NOOP word constant.
  - B0/B1/B2 state encodings.
  - The meta-valid predicate.
- One sub-module, `cmd_fifo`: synchronous FIFO with width 24 and depth `FIFO_DEPTH`, with push/pop/full/empty signals and the same async active-low reset.
- FSM, validation, stall and output register live in the top level.

## Test plan
- Bytes 0x04, 0x00, 0x20 (FILTER_BIAS, data 0x00020), `accel_busy` = 0 -> `master_bus` = 0x040020 for one cycle, 2 edges after the third byte, then 0x000000.
- Three DATA words with `accel_busy` = 1 -> `master_bus` stays 0. Release busy -> words appear on 3 consecutive cycles, in order.
- Meta 01100 word -> no bus activity, one `frame_err` pulse, `err_count` = 1.
- Send 2 bytes, idle 255 cycles, then send 0x00, 0x00, 0x00 -> one timeout error; the next 3 bytes frame as a clean NOOP word.
- Fill the FIFO to `FIFO_DEPTH` with busy-stalled DATA words -> `host_ready` = 0 in B2 only; the FIFO accepts again the cycle after the first pop.
- With `CMD_PARITY_EN` defined, send 0x88, 0x00, 0x01 (popcount 3 -> pass, `master_bus` = 0x080001) and 0x08, 0x00, 0x01 (popcount 2 -> dropped, `frame_err` pulse).
